// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed RV32I load/store data memory with a valid/ready request port,
// programmable wait states, and optional access checking enabled by DMEM_ERR_CHECK_EN.
`timescale 1ns/1ps
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic       WS_ZERO = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD = WS_ZERO ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_busy;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_commit;
    logic          w_op_we;
    logic [2:0]    w_op_f3;
    logic [31:0]   w_op_addr;
    logic [31:0]   w_op_wdata;
    logic [2:0]    w_f3_eff;
    logic [1:0]    w_lane_eff;
    logic          w_err;
    logic [AW-1:0] w_word_idx;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_shift;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wrep;
    logic [31:0]   w_merged;

    assign w_accept     = req_valid & r_req_ready;
    assign w_enter_resp = ((r_state == S_IDLE) & w_accept & WS_ZERO) |
                          ((r_state == S_WAIT) & (r_cnt == 4'd0));

    // With no wait states the access executes on the accept edge, before capture.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_op_we    = req_we;
            w_op_f3    = req_funct3;
            w_op_addr  = req_addr;
            w_op_wdata = req_wdata;
        end else begin
            w_op_we    = r_we;
            w_op_f3    = r_funct3;
            w_op_addr  = r_addr;
            w_op_wdata = r_wdata;
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    logic w_illegal;
    logic w_misalign;
    logic w_range;

    // Access legality: funct3, natural alignment and address range.
    always_comb begin
        if (w_op_we) begin
            w_illegal = w_op_f3[2] | (w_op_f3[1:0] == 2'b11);
        end else begin
            w_illegal = (w_op_f3[1:0] == 2'b11) | (w_op_f3 == 3'b110);
        end
        case (w_op_f3[1:0])
            2'b01:   w_misalign = w_op_addr[0];
            2'b10:   w_misalign = |w_op_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
        w_range    = (w_op_addr >> (AW + 2)) != 32'd0;
        w_err      = w_illegal | w_misalign | w_range;
        w_f3_eff   = w_op_f3;
        w_lane_eff = w_op_addr[1:0];
    end
`else
    logic w_illegal;
    logic w_unused_hi;

    // Unchecked mode: illegal funct3 folds to a word access, misalignment rounds down.
    always_comb begin
        if (w_op_we) begin
            w_illegal = w_op_f3[2] | (w_op_f3[1:0] == 2'b11);
        end else begin
            w_illegal = (w_op_f3[1:0] == 2'b11) | (w_op_f3 == 3'b110);
        end
        if (w_illegal) begin
            w_f3_eff = 3'b010;
        end else begin
            w_f3_eff = w_op_f3;
        end
        case (w_f3_eff[1:0])
            2'b00:   w_lane_eff = w_op_addr[1:0];
            2'b01:   w_lane_eff = {w_op_addr[1], 1'b0};
            default: w_lane_eff = 2'b00;
        endcase
        w_err = 1'b0;
    end

    assign w_unused_hi = ^w_op_addr[31:AW+2];
`endif

    assign w_word_idx = w_op_addr[AW+1:2];
    assign w_rd_word  = r_mem[w_word_idx];
    assign w_shift    = w_rd_word >> {w_lane_eff, 3'b000};
    assign w_commit   = w_enter_resp & w_op_we & ~w_err & ~rst;

    // Load extraction and store lane merge.
    always_comb begin
        case (w_f3_eff)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_load = w_shift;
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_shift[15:0]};
            default: w_load = 32'd0;
        endcase
        case (w_f3_eff[1:0])
            2'b00: begin
                w_be   = 4'b0001 << w_lane_eff;
                w_wrep = {4{w_op_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = 4'b0011 << w_lane_eff;
                w_wrep = {2{w_op_wdata[15:0]}};
            end
            2'b10: begin
                w_be   = 4'b1111;
                w_wrep = w_op_wdata;
            end
            default: begin
                w_be   = 4'b0000;
                w_wrep = 32'd0;
            end
        endcase
        w_merged = w_rd_word;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_merged[8*i +: 8] = w_wrep[8*i +: 8];
            end else begin
                w_merged[8*i +: 8] = w_rd_word[8*i +: 8];
            end
        end
    end

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_word_idx] <= w_merged;
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
        end else begin
            if (w_enter_resp) begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
                r_resp_rdata <= (w_op_we | w_err) ? 32'd0 : w_load;
                r_resp_err   <= w_err;
                r_req_ready  <= 1'b0;
                r_busy       <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_resp_valid <= 1'b0;
                        if (w_accept) begin
                            r_state     <= S_WAIT;
                            r_cnt       <= WS_LOAD;
                            r_req_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end else begin
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                    S_RESP: begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                endcase
            end
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: two instances (0 and 3 wait states) against a
// byte-level reference memory, plus directed literal expectations.
`timescale 1ns/1ps
module tb_data_mem_lsu;
    localparam int DEP0 = 1024;
    localparam int DEP1 = 64;
    localparam int WS0  = 0;
    localparam int WS1  = 3;
`ifdef DMEM_ERR_CHECK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        valid_i [2];
    logic        we_i    [2];
    logic [2:0]  f3_i    [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic        ready_o [2];
    logic        rvalid_o[2];
    logic [31:0] rdata_o [2];
    logic        err_o   [2];
    logic        busy_o  [2];

    int checks   = 0;
    int failures = 0;

    data_mem_lsu #(.DEPTH_WORDS(DEP0), .WAIT_STATES(WS0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(valid_i[0]), .req_ready(ready_o[0]),
        .req_we(we_i[0]), .req_funct3(f3_i[0]), .req_addr(addr_i[0]), .req_wdata(wdata_i[0]),
        .resp_valid(rvalid_o[0]), .resp_rdata(rdata_o[0]), .resp_err(err_o[0]), .busy(busy_o[0])
    );

    data_mem_lsu #(.DEPTH_WORDS(DEP1), .WAIT_STATES(WS1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid_i[1]), .req_ready(ready_o[1]),
        .req_we(we_i[1]), .req_funct3(f3_i[1]), .req_addr(addr_i[1]), .req_wdata(wdata_i[1]),
        .resp_valid(rvalid_o[1]), .resp_rdata(rdata_o[1]), .resp_err(err_o[1]), .busy(busy_o[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model state
    bit          model_on = 1'b0;
    int          left   [2];
    bit          e_ready[2];
    bit          e_busy [2];
    bit          e_valid[2];
    bit          e_dchk [2];
    logic [31:0] e_rdata[2];
    bit          e_err  [2];
    bit          p_we   [2];
    logic [2:0]  p_f3   [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata[2];
    logic [31:0] mm     [2][DEP0];

    task automatic model_exec(input int d);
        int          sz;
        int          off;
        int          wi;
        int          dep;
        bit          legal;
        bit          err;
        logic [31:0] a;
        logic [31:0] v;
        dep = (d == 0) ? DEP0 : DEP1;
        a   = p_addr[d];
        case (p_f3[d][1:0])
            2'b00:   sz = 1;
            2'b01:   sz = 2;
            default: sz = 4;
        endcase
        if (p_we[d]) legal = (p_f3[d] <= 3'd2);
        else         legal = (p_f3[d] != 3'd3) && (p_f3[d] != 3'd6) && (p_f3[d] != 3'd7);
        if (ERRCHK) begin
            err = !legal || ((a % sz) != 0) || (a >= 32'(4 * dep));
        end else begin
            err = 1'b0;
            if (!legal) sz = 4;
            a = a - (a % sz);
        end
        wi  = int'((a / 4) % dep);
        off = int'(a % 4);
        e_err[d] = err;
        if (err) begin
            e_rdata[d] = 32'd0;
        end else if (p_we[d]) begin
            for (int b = 0; b < sz; b++) mm[d][wi][8*(off+b) +: 8] = p_wdata[d][8*b +: 8];
            e_rdata[d] = 32'd0;
        end else begin
            v = mm[d][wi] >> (8 * off);
            if (sz == 1) begin
                v = {24'd0, v[7:0]};
                if (legal && !p_f3[d][2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 2) begin
                v = {16'd0, v[15:0]};
                if (legal && !p_f3[d][2] && v[15]) v = v | 32'hFFFF_0000;
            end
            e_rdata[d] = v;
        end
    endtask

    // Model: a request occupies 1+wait-states cycles; its result appears in the last one.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                model_on   = 1'b1;
                left[d]    = 0;
                e_ready[d] = 1'b0;
                e_busy[d]  = 1'b0;
                e_valid[d] = 1'b0;
                e_rdata[d] = 32'd0;
                e_err[d]   = 1'b0;
                e_dchk[d]  = 1'b1;
            end else if (model_on) begin
                e_dchk[d] = 1'b0;
                if (left[d] > 0) begin
                    left[d]--;
                end else if (valid_i[d] && e_ready[d]) begin
                    p_we[d]    = we_i[d];
                    p_f3[d]    = f3_i[d];
                    p_addr[d]  = addr_i[d];
                    p_wdata[d] = wdata_i[d];
                    left[d]    = ((d == 0) ? WS0 : WS1) + 1;
                end
                if (left[d] == 1) begin
                    model_exec(d);
                    e_valid[d] = 1'b1;
                    e_dchk[d]  = 1'b1;
                end else begin
                    e_valid[d] = 1'b0;
                end
                e_ready[d] = (left[d] == 0);
                e_busy[d]  = (left[d] != 0);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d_ready", d), 32'(ready_o[d]), 32'(e_ready[d]));
                chk($sformatf("d%0d_busy", d), 32'(busy_o[d]), 32'(e_busy[d]));
                chk($sformatf("d%0d_resp_valid", d), 32'(rvalid_o[d]), 32'(e_valid[d]));
                if (e_dchk[d]) begin
                    chk($sformatf("d%0d_rdata", d), rdata_o[d], e_rdata[d]);
                    chk($sformatf("d%0d_err", d), 32'(err_o[d]), 32'(e_err[d]));
                end
            end
        end
    end

    task automatic do_req(input int d, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int n;
        rd = 32'd0;
        er = 1'b0;
        @(negedge clk);
        valid_i[d] = 1'b1;
        we_i[d]    = we;
        f3_i[d]    = f3;
        addr_i[d]  = addr;
        wdata_i[d] = wdata;
        n = 0;
        while (!ready_o[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        valid_i[d] = 1'b0;
        we_i[d]    = ~we;
        f3_i[d]    = 3'b111;
        addr_i[d]  = 32'hFFFF_FFFF;
        wdata_i[d] = 32'h5A5A_5A5A;
        n = 0;
        while (!rvalid_o[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("resp_timeout", 32'd0, 32'd1);
        rd = rdata_o[d];
        er = err_o[d];
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] rd_t;
        logic [9:0]  rh;
        logic [9:0]  vh;
        clk = 1'b0;
        rst = 1'b1;
        rd_t = 32'd0;
        for (int d = 0; d < 2; d++) begin
            valid_i[d] = 1'b0;
            we_i[d]    = 1'b0;
            f3_i[d]    = 3'd0;
            addr_i[d]  = 32'd0;
            wdata_i[d] = 32'd0;
            for (int w = 0; w < DEP0; w++) mm[d][w] = 32'd0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_o[0]), 32'd0);
        chk("rst_resp_valid", 32'(rvalid_o[1]), 32'd0);
        chk("rst_rdata", rdata_o[0], 32'd0);
        chk("rst_busy", 32'(busy_o[1]), 32'd0);
        rst = 1'b0;

        do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er);
        chk("sw_rdata_zero", rd, 32'd0);
        do_req(0, 1'b0, 3'b000, 32'h13, 32'd0, rd, er);
        chk("lb_0x13", rd, 32'hFFFF_FFDE);
        do_req(0, 1'b0, 3'b100, 32'h13, 32'd0, rd, er);
        chk("lbu_0x13", rd, 32'h0000_00DE);
        do_req(0, 1'b0, 3'b001, 32'h12, 32'd0, rd, er);
        chk("lh_0x12", rd, 32'hFFFF_DEAD);
        do_req(0, 1'b0, 3'b101, 32'h10, 32'd0, rd, er);
        chk("lhu_0x10", rd, 32'h0000_BEEF);

        do_req(0, 1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, er);
        do_req(0, 1'b1, 3'b000, 32'h21, 32'h1234_56AA, rd, er);
        do_req(0, 1'b1, 3'b001, 32'h22, 32'hABCD_5566, rd, er);
        do_req(0, 1'b0, 3'b010, 32'h20, 32'd0, rd, er);
        chk("merge_lw_0x20", rd, 32'h5566_AA44);

`ifdef DMEM_ERR_CHECK_EN
        do_req(0, 1'b1, 3'b010, 32'h30, 32'h0102_0304, rd, er);
        do_req(0, 1'b1, 3'b001, 32'h31, 32'h0000_BEEF, rd, er);
        chk("sh_mis_err", 32'(er), 32'd1);
        do_req(0, 1'b0, 3'b010, 32'h30, 32'd0, rd, er);
        chk("sh_mis_nowrite", rd, 32'h0102_0304);
        do_req(0, 1'b0, 3'b010, 32'(4 * DEP0), 32'd0, rd, er);
        chk("lw_oor_err", 32'(er), 32'd1);
        chk("lw_oor_rdata", rd, 32'd0);
        do_req(0, 1'b0, 3'b011, 32'h20, 32'd0, rd, er);
        chk("ld_f3_011_err", 32'(er), 32'd1);
`else
        do_req(0, 1'b1, 3'b010, 32'(4 * DEP0 + 8), 32'h1234_5678, rd, er);
        do_req(0, 1'b0, 3'b010, 32'h8, 32'd0, rd, er);
        chk("wrap_lw_0x8", rd, 32'h1234_5678);
        chk("wrap_err", 32'(er), 32'd0);
        do_req(0, 1'b0, 3'b010, 32'h22, 32'd0, rd, er);
        chk("lw_align_down", rd, 32'h5566_AA44);
        do_req(0, 1'b0, 3'b011, 32'h20, 32'd0, rd, er);
        chk("ld_f3_011_as_lw", rd, 32'h5566_AA44);
`endif

        // Wait-state timing with req_valid held high across two requests.
        do_req(1, 1'b1, 3'b010, 32'h10, 32'hA5A5_0001, rd, er);
        @(negedge clk);
        chk("ws3_idle_ready", 32'(ready_o[1]), 32'd1);
        valid_i[1] = 1'b1;
        we_i[1]    = 1'b0;
        f3_i[1]    = 3'b010;
        addr_i[1]  = 32'h10;
        rh = 10'd0;
        vh = 10'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rh[k] = ready_o[1];
            vh[k] = rvalid_o[1];
            if (k == 3) rd_t = rdata_o[1];
        end
        valid_i[1] = 1'b0;
        chk("ws3_ready_hist", 32'(rh), 32'h0000_0210);
        chk("ws3_valid_hist", 32'(vh), 32'h0000_0108);
        chk("ws3_lw", rd_t, 32'hA5A5_0001);

        // Reset during WAIT of a store drops it.
        do_req(1, 1'b1, 3'b010, 32'h40, 32'd0, rd, er);
        @(negedge clk);
        valid_i[1] = 1'b1;
        we_i[1]    = 1'b1;
        f3_i[1]    = 3'b010;
        addr_i[1]  = 32'h40;
        wdata_i[1] = 32'hCAFE_F00D;
        @(negedge clk);
        chk("mid_busy", 32'(busy_o[1]), 32'd1);
        valid_i[1] = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_ready", 32'(ready_o[1]), 32'd0);
            chk("mid_rst_valid", 32'(rvalid_o[1]), 32'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_resp", 32'(rvalid_o[1]), 32'd0);
        end
        do_req(1, 1'b0, 3'b010, 32'h40, 32'd0, rd, er);
        chk("dropped_store_lw", rd, 32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
